qsram_access_sequencer: RTL and testbench

//  Upstream control stage for the QSRAM cell array. Turns host read/write requests and periodic

---
 rtl/qsram_access_sequencer_pkg.sv | 16 +
 rtl/qsram_access_sequencer_if.sv | 23 ++
 rtl/qsram_access_sequencer_refresh_timer.sv | 33 +++
 rtl/qsram_access_sequencer.sv | 120 ++++++++++++
 tb/tb_qsram_access_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/qsram_access_sequencer_pkg.sv
// Shared types and default geometry for the QSRAM access sequencer.
package qsram_pkg;
    localparam int ROWS_DEF     = 16;
    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int STROBE_DEF   = 2;
    localparam int REFRESH_DEF  = 64;

    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t SETUP   = 2'd1;
    localparam state_t PULSE   = 2'd2;
    localparam state_t RECOVER = 2'd3;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_RF} op_e;
endpackage

// File: rtl/qsram_access_sequencer_if.sv
// Host request/response channel of the QSRAM access sequencer.
interface qsram_access_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddr;
    logic [DATA_W-1:0] ReqData;
    logic              RspValid;
    logic [DATA_W-1:0] RspData;
    logic              RspErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData,
        input  ReqReady, RspValid, RspData, RspErr
    );
    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData,
        output ReqReady, RspValid, RspData, RspErr
    );
endinterface

// File: rtl/qsram_access_sequencer_refresh_timer.sv
// Free-running refresh down counter raising a pending request every interval.
module qsram_refresh_timer
    import qsram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic RefreshTaken,
    output logic RefreshPending,
    output logic RefreshOverrun
);
    localparam int TW = $clog2(REFRESH_INTERVAL);

    logic [TW-1:0] timer;
    logic          tick;

    assign tick = (timer == '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            timer          <= TW'(REFRESH_INTERVAL - 1);
            RefreshPending <= 1'b0;
            RefreshOverrun <= 1'b0;
        end else begin
            timer <= tick ? TW'(REFRESH_INTERVAL - 1) : timer - 1'b1;
            // A fresh tick outranks the take so a back-to-back request is not lost.
            if (tick)              RefreshPending <= 1'b1;
            else if (RefreshTaken) RefreshPending <= 1'b0;
            if (tick && RefreshPending && !RefreshTaken) RefreshOverrun <= 1'b1;
        end
    end
endmodule

// File: rtl/qsram_access_sequencer.sv
// Sequences host reads/writes and periodic refresh into one-hot row strobes
// for the QSRAM cell array: SETUP, STROBE_CYCLES of PULSE, then RECOVER.
module qsram_access_sequencer
    import qsram_pkg::*;
#(
    parameter int ROWS             = ROWS_DEF,
    parameter int ADDR_W           = ADDR_W_DEF,
    parameter int DATA_W           = DATA_W_DEF,
    parameter int STROBE_CYCLES    = STROBE_DEF,
    parameter int REFRESH_INTERVAL = REFRESH_DEF
) (
    input  logic                      Clock,
    input  logic                      Reset,
    qsram_access_sequencer_if.slave   host,
    output logic [ROWS-1:0]           WriteEdge,
    output logic [ROWS-1:0]           ReadEdge,
    output logic [ROWS-1:0]           RefreshEdge,
    output logic [DATA_W-1:0]         ArrayInData,
    input  logic [DATA_W-1:0]         ArrayOutData,
    output logic                      RefreshOverrun
);
    localparam int CNT_W = $clog2(STROBE_CYCLES + 1);

    state_t            state;
    op_e               op;
    logic [ADDR_W-1:0] rowAddr;
    logic [ADDR_W-1:0] refreshPtr;
    logic [CNT_W-1:0]  strobeCnt;
    logic              pending;
    logic              taken;
    logic              accept;
    logic              inRange;
    logic [ROWS-1:0]   rowOneHot;
    logic              rspValid;
    logic [DATA_W-1:0] rspData;
    logic              rspErr;

    qsram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) uTimer (
        .Clock          (Clock),
        .Reset          (Reset),
        .RefreshTaken   (taken),
        .RefreshPending (pending),
        .RefreshOverrun (RefreshOverrun)
    );

    // Refresh has priority in IDLE, so the host only sees ready when none is owed.
    assign taken         = (state == IDLE) && pending;
    assign host.ReqReady = (state == IDLE) && !pending;
    assign accept        = host.ReqValid && host.ReqReady;
    assign inRange       = 32'(rowAddr) < ROWS;
    assign rowOneHot     = inRange ? (ROWS'(1) << rowAddr) : '0;

    assign host.RspValid = rspValid;
    assign host.RspData  = rspData;
    assign host.RspErr   = rspErr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            op          <= OP_RD;
            rowAddr     <= '0;
            refreshPtr  <= '0;
            strobeCnt   <= '0;
            WriteEdge   <= '0;
            ReadEdge    <= '0;
            RefreshEdge <= '0;
            ArrayInData <= '0;
            rspValid    <= 1'b0;
            rspData     <= '0;
            rspErr      <= 1'b0;
        end else begin
            rspValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (taken) begin
                        state       <= SETUP;
                        op          <= OP_RF;
                        rowAddr     <= refreshPtr;
                        ArrayInData <= '0;
                    end else if (accept) begin
                        state       <= SETUP;
                        op          <= host.ReqWrite ? OP_WR : OP_RD;
                        rowAddr     <= host.ReqAddr;
                        ArrayInData <= host.ReqData;
                    end
                end
                SETUP: begin
                    state       <= PULSE;
                    strobeCnt   <= '0;
                    WriteEdge   <= (op == OP_WR) ? rowOneHot : '0;
                    ReadEdge    <= (op == OP_RD) ? rowOneHot : '0;
                    RefreshEdge <= (op == OP_RF) ? rowOneHot : '0;
                end
                PULSE: begin
                    if (strobeCnt == CNT_W'(STROBE_CYCLES - 1)) begin
                        state       <= RECOVER;
                        WriteEdge   <= '0;
                        ReadEdge    <= '0;
                        RefreshEdge <= '0;
                        // Cell output is still driven by the read strobe on this last cycle.
                        if (op == OP_RD) begin
                            rspValid <= 1'b1;
                            rspData  <= inRange ? ArrayOutData : '0;
                            rspErr   <= !inRange;
                        end
                    end else begin
                        strobeCnt <= strobeCnt + 1'b1;
                    end
                end
                RECOVER: begin
                    state       <= IDLE;
                    ArrayInData <= '0;
                    if (op == OP_RF)
                        refreshPtr <= (refreshPtr == ADDR_W'(ROWS - 1)) ? '0 : refreshPtr + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qsram_access_sequencer.sv
// Bench for qsram_access_sequencer: behavioural cell array, read scoreboard,
// vector table of host ops plus directed refresh / arbitration / reset sequences.
module tb_qsram_access_sequencer;
    localparam int ROWS = 16, ADDR_W = 5, DATA_W = 8, S = 2, RI = 64;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    qsram_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();
    logic [ROWS-1:0]   WriteEdge, ReadEdge, RefreshEdge;
    logic [DATA_W-1:0] ArrayInData, ArrayOutData;
    logic              RefreshOverrun;
    logic [3*ROWS-1:0] allEdges;

    qsram_access_sequencer #(
        .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STROBE_CYCLES(S), .REFRESH_INTERVAL(RI)
    ) dut (
        .Clock(Clock), .Reset(Reset), .host(host),
        .WriteEdge(WriteEdge), .ReadEdge(ReadEdge), .RefreshEdge(RefreshEdge),
        .ArrayInData(ArrayInData), .ArrayOutData(ArrayOutData),
        .RefreshOverrun(RefreshOverrun)
    );

    assign allEdges = {WriteEdge, ReadEdge, RefreshEdge};

    int nTests = 0, nFail = 0;
    int cyc;

    // Behavioural cell array
    logic [DATA_W-1:0] mem [ROWS] = '{default: 8'h00};
    always @(posedge Clock)
        for (int r = 0; r < ROWS; r++)
            if (WriteEdge[r]) mem[r] <= ArrayInData;
    always_comb begin
        ArrayOutData = 8'h00;
        for (int r = 0; r < ROWS; r++)
            if (ReadEdge[r]) ArrayOutData = mem[r];
    end

    always @(posedge Clock or posedge Reset)
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3*ROWS-1:0] expEdge(input int kind, input int row);
        logic [3*ROWS-1:0] v;
        v = '0;
        if (row < ROWS) v[(2 - kind) * ROWS + row] = 1'b1;  // kind 0=write 1=read 2=refresh
        return v;
    endfunction

    // Read scoreboard
    typedef struct { logic [DATA_W-1:0] data; logic err; } rsp_t;
    rsp_t sbQ[$];

    always @(negedge Clock) begin
        rsp_t e;
        if (!Reset && host.RspValid) begin
            if (sbQ.size() == 0) begin
                nTests++; nFail++;
                $display("FAIL unexpectedRsp: got RspValid=1 with data %0h, required none", host.RspData);
            end else begin
                e = sbQ.pop_front();
                chk("rspData", 64'(host.RspData), 64'(e.data));
                chk("rspErr",  64'(host.RspErr),  64'(e.err));
            end
        end
    end

    always @(negedge Clock)
        if ($countones(allEdges) > 1) begin
            nFail++;
            $display("FAIL edgeOneHot: got %0h, required at most one bit", allEdges);
        end

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] expData;
        logic              expErr;
    } vec_t;
    vec_t vecs[13];

    task automatic doOp(input vec_t v);
        int guard = 0;
        while (!host.ReqReady && guard < 200) begin @(negedge Clock); guard++; end
        chk("readyWait", 64'(host.ReqReady), 64'(1));
        host.ReqValid = 1'b1; host.ReqWrite = v.wr; host.ReqAddr = v.addr; host.ReqData = v.data;
        if (!v.wr) sbQ.push_back(rsp_t'{v.expData, v.expErr});
        @(negedge Clock);
        host.ReqValid = 1'b0;
        host.ReqAddr  = ADDR_W'($urandom);
        host.ReqData  = DATA_W'($urandom);
        host.ReqWrite = 1'($urandom);
        chk("setupEdges", 64'(allEdges), 64'(0));
        chk("setupReady", 64'(host.ReqReady), 64'(0));
        repeat (S) begin
            @(negedge Clock);
            chk("pulseEdges", 64'(allEdges), 64'(expEdge(v.wr ? 0 : 1, int'(v.addr))));
            if (v.wr) chk("arrayIn", 64'(ArrayInData), 64'(v.data));
        end
        @(negedge Clock);
        chk("recoverEdges", 64'(allEdges), 64'(0));
        chk("recoverRsp", 64'(host.RspValid), 64'(!v.wr));
        @(negedge Clock);
    endtask

    task automatic waitRefresh(input int expCyc, input int row);
        while (RefreshEdge == '0 && cyc < expCyc + 10) @(negedge Clock);
        chk("rfCycle", 64'(cyc), 64'(expCyc));
        chk("rfEdge", 64'(RefreshEdge), 64'(1) << row);
        @(negedge Clock);
        chk("rfEdge2", 64'(RefreshEdge), 64'(1) << row);
        @(negedge Clock);
        chk("rfEnd", 64'(RefreshEdge), 64'(0));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd3,  8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 5'd3,  8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, 5'd0,  8'h3C, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 5'd15, 8'hC3, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 5'd15, 8'h00, 8'hC3, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  8'h00, 8'h3C, 1'b0};
        vecs[6]  = '{1'b1, 5'd4,  8'h44, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 5'd20, 8'hEE, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 5'd20, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 5'd4,  8'h00, 8'h44, 1'b0};
        vecs[10] = '{1'b1, 5'd3,  8'h5A, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 5'd3,  8'h00, 8'h5A, 1'b0};
        vecs[12] = '{1'b0, 5'd31, 8'h00, 8'h00, 1'b1};

        host.ReqValid = 1'b0; host.ReqWrite = 1'b0; host.ReqAddr = '0; host.ReqData = '0;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("rstEdges",   64'(allEdges), 64'(0));
        chk("rstInData",  64'(ArrayInData), 64'(0));
        chk("rstRspV",    64'(host.RspValid), 64'(0));
        chk("rstRspD",    64'(host.RspData), 64'(0));
        chk("rstRspE",    64'(host.RspErr), 64'(0));
        chk("rstOverrun", 64'(RefreshOverrun), 64'(0));
        chk("rstReady",   64'(host.ReqReady), 64'(1));
        Reset = 1'b0;

        // Idle refresh cadence, including pointer wrap after ROWS refreshes
        for (int k = 0; k <= ROWS; k++) waitRefresh(66 + RI * k, k % ROWS);
        chk("noOverrun", 64'(RefreshOverrun), 64'(0));

        for (int i = 0; i < 13; i++) doOp(vecs[i]);

        // Host accept coincides with timer expiry; held second request waits behind refresh
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        while (cyc < 63) @(negedge Clock);
        chk("b2bReady", 64'(host.ReqReady), 64'(1));
        host.ReqValid = 1'b1; host.ReqWrite = 1'b0; host.ReqAddr = 5'd3; host.ReqData = 8'h00;
        sbQ.push_back(rsp_t'{8'h5A, 1'b0});
        for (int k = 64; k <= 77; k++) begin
            logic [3*ROWS-1:0] e;
            @(negedge Clock);
            case (k)
                65, 66:  e = expEdge(1, 3);
                70, 71:  e = expEdge(2, 0);
                75, 76:  e = expEdge(0, 7);
                default: e = '0;
            endcase
            chk("b2bEdges", 64'(allEdges), 64'(e));
            chk("b2bReady", 64'(host.ReqReady), 64'(k == 73));
            if (k == 75 || k == 76) chk("b2bInData", 64'(ArrayInData), 64'(8'h77));
            if (k == 64) begin host.ReqWrite = 1'b1; host.ReqAddr = 5'd7; host.ReqData = 8'h77; end
            if (k == 74) host.ReqValid = 1'b0;
        end
        @(negedge Clock);

        // Reset during PULSE aborts the read and restarts the timer
        chk("abortReady", 64'(host.ReqReady), 64'(1));
        host.ReqValid = 1'b1; host.ReqWrite = 1'b0; host.ReqAddr = 5'd3;
        @(negedge Clock);
        host.ReqValid = 1'b0;
        @(negedge Clock);
        chk("abortPulse", 64'(allEdges), 64'(expEdge(1, 3)));
        Reset = 1'b1;
        #1;
        chk("abortEdges", 64'(allEdges), 64'(0));
        chk("abortRsp", 64'(host.RspValid), 64'(0));
        @(negedge Clock);
        Reset = 1'b0;
        waitRefresh(66, 0);

        chk("sbEmpty", 64'(sbQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
